// File: rtl/shift_seq32_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq32_if
// Description : Handshake/data bundle between the ALU control decode (master)
//               and the multi-cycle shift unit shift_seq32 (slave).
//   master drives : start, a, shamt, op
//   slave drives  : ready, busy, done, out, zero
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq32_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;   // request, sampled only while ready=1
    logic [WIDTH-1:0] a;       // operand
    logic [SHW-1:0]   shamt;   // shift amount
    logic [1:0]       op;      // 00 sll, 01 srl, 10 sra, 11 rotr/srl
    logic             ready;   // unit idle, will accept start
    logic             busy;    // shifting in progress
    logic             done;    // one-cycle result-valid pulse
    logic [WIDTH-1:0] out;     // registered result, held until next done
    logic             zero;    // out == 0, registered with out

    modport master (
        output start, a, shamt, op,
        input  ready, busy, done, out, zero
    );

    modport slave (
        input  start, a, shamt, op,
        output ready, busy, done, out, zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq32.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq32
// Description : Multi-cycle shifter for the ALU shift path (sll/srl/sra).
//               Captures one operand + amount per start/ready handshake,
//               shifts by at most STEP bits per RUN cycle and then presents
//               the registered result with a one-cycle done pulse.
// Ports       : clk   - clock, rising edge
//               rst_n - synchronous active-low reset
//               sif   - shift_seq32_if.slave (start/a/shamt/op in,
//                       ready/busy/done/out/zero out)
// Options     : SHIFT_SEQ_ROTATE_EN - when defined, op=11 is rotate right;
//               otherwise op=11 behaves as srl.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq32 #(
    parameter int WIDTH = 32,   // operand/result width
    parameter int SHW   = 5,    // shift-amount width, 2**SHW == WIDTH
    parameter int STEP  = 8     // max bits shifted per RUN cycle
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    shift_seq32_if.slave      sif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One extra bit so STEP == WIDTH is representable for the comparison.
    localparam logic [SHW:0] c_step = STEP[SHW:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_rem;
    logic [1:0]       r_opr;
    logic [WIDTH-1:0] r_out;
    logic             r_zero;

    logic [SHW-1:0]   w_step;
    logic [SHW-1:0]   w_rem_nxt;
    logic [WIDTH-1:0] w_acc_shf;

    // step = min(rem, STEP). rem never exceeds WIDTH-1, so the chosen value
    // always fits in SHW bits even when STEP == WIDTH.
    always_comb begin
        w_step = r_rem;
        if ({1'b0, r_rem} > c_step) begin
            w_step = c_step[SHW-1:0];
        end
    end

    assign w_rem_nxt = r_rem - w_step;

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [SHW:0] c_width = WIDTH[SHW:0];
    logic [SHW:0] w_rot_amt;
    // Left part of the rotate; step is >= 1 in RUN so this stays < WIDTH.
    assign w_rot_amt = c_width - {1'b0, w_step};
`endif

    always_comb begin
        w_acc_shf = r_acc >> w_step;            // srl (and op=11 without rotate)
        case (r_opr)
            2'b00:   w_acc_shf = r_acc << w_step;
            2'b10:   w_acc_shf = $signed(r_acc) >>> w_step;
`ifdef SHIFT_SEQ_ROTATE_EN
            2'b11:   w_acc_shf = (r_acc >> w_step) | (r_acc << w_rot_amt);
`endif
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (sif.start) begin
                    w_state_nxt = (sif.shamt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_rem_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. out/zero load on the edge that enters DONE so they are
    // valid in the same cycle as the done pulse and hold afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_rem  <= '0;
            r_opr  <= '0;
            r_out  <= '0;
            r_zero <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sif.start) begin
                        r_acc <= sif.a;
                        r_rem <= sif.shamt;
                        r_opr <= sif.op;
                        if (sif.shamt == '0) begin
                            r_out  <= sif.a;
                            r_zero <= (sif.a == '0);
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_shf;
                    r_rem <= w_rem_nxt;
                    if (w_rem_nxt == '0) begin
                        r_out  <= w_acc_shf;
                        r_zero <= (w_acc_shf == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are decoded from state only.
    assign sif.ready = (r_state == S_IDLE);
    assign sif.busy  = (r_state == S_RUN);
    assign sif.done  = (r_state == S_DONE);
    assign sif.out   = r_out;
    assign sif.zero  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq32.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_seq32
// Description : Directed self-checking bench for shift_seq32 (STEP=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_seq32;

    localparam int c_width = 32;
    localparam int c_shw   = 5;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    shift_seq32_if #(.WIDTH(c_width), .SHW(c_shw)) sif ();

    shift_seq32 #(.WIDTH(c_width), .SHW(c_shw), .STEP(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: accept at edge T, then count edges until done.
    // exp_lat = ceil(shamt/8); busy is expected for exp_lat cycles.
    // With noise=1, start is held high with random data while the unit runs.
    task automatic run_txn(input string tag, input logic [31:0] a_v,
                           input logic [4:0] sh_v, input logic [1:0] op_v,
                           input int exp_lat, input logic [31:0] exp_out,
                           input logic exp_zero, input bit noise);
        int n;
        int nbusy;
        @(negedge clk);
        chk({tag, ".ready_pre"}, {31'd0, sif.ready}, 32'd1);
        sif.start = 1'b1;
        sif.a     = a_v;
        sif.shamt = sh_v;
        sif.op    = op_v;
        @(posedge clk);
        #1;
        sif.start = noise;
        sif.a     = $urandom;
        sif.shamt = 5'($urandom_range(1, 31));
        sif.op    = 2'($urandom_range(0, 3));
        n     = 0;
        nbusy = 0;
        while (!sif.done && n < 40) begin
            if (sif.busy) nbusy++;
            @(posedge clk);
            #1;
            n++;
            if (noise) sif.a = $urandom;
        end
        sif.start = 1'b0;
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".busy_cycles"}, nbusy, exp_lat);
        chk({tag, ".out"}, sif.out, exp_out);
        chk({tag, ".zero"}, {31'd0, sif.zero}, {31'd0, exp_zero});
        @(posedge clk);
        #1;
        chk({tag, ".ready_post"}, {31'd0, sif.ready}, 32'd1);
        chk({tag, ".done_post"}, {31'd0, sif.done}, 32'd0);
        chk({tag, ".out_hold"}, sif.out, exp_out);
        if (noise) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1;
                chk({tag, ".single_done"}, {31'd0, sif.done}, 32'd0);
            end
        end
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        sif.start = 1'b0;
        sif.a     = '0;
        sif.shamt = '0;
        sif.op    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", {31'd0, sif.ready}, 32'd1);
        chk("rst.busy",  {31'd0, sif.busy},  32'd0);
        chk("rst.done",  {31'd0, sif.done},  32'd0);
        chk("rst.out",   sif.out, 32'd0);
        chk("rst.zero",  {31'd0, sif.zero},  32'd1);
        rst_n = 1'b1;

        run_txn("sll4",     32'h0000_00F0, 5'd4,  2'b00, 1, 32'h0000_0F00, 1'b0, 1'b0);
        run_txn("sra31",    32'h8000_0000, 5'd31, 2'b10, 4, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_txn("srl31",    32'h8000_0000, 5'd31, 2'b01, 4, 32'h0000_0001, 1'b0, 1'b0);
        run_txn("sh0",      32'h1234_5678, 5'd0,  2'b10, 0, 32'h1234_5678, 1'b0, 1'b0);
        run_txn("sll31",    32'hFFFF_FFFF, 5'd31, 2'b00, 4, 32'h8000_0000, 1'b0, 1'b0);
        run_txn("srl1",     32'h0000_0001, 5'd1,  2'b01, 1, 32'h0000_0000, 1'b1, 1'b0);
        run_txn("sra_pos",  32'h4000_0000, 5'd30, 2'b10, 4, 32'h0000_0001, 1'b0, 1'b0);
        run_txn("sra20",    32'hF000_0000, 5'd20, 2'b10, 3, 32'hFFFF_FF00, 1'b0, 1'b0);
        run_txn("noise",    32'h0000_00F0, 5'd20, 2'b00, 3, 32'h0F00_0000, 1'b0, 1'b1);

        // Reset during the 2nd RUN cycle of a shamt=20 transaction.
        @(negedge clk);
        sif.start = 1'b1;
        sif.a     = 32'hDEAD_BEEF;
        sif.shamt = 5'd20;
        sif.op    = 2'b01;
        @(posedge clk);          // accepted; RUN cycle 1 follows
        #1;
        sif.start = 1'b0;
        @(posedge clk);          // RUN cycle 2 follows
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst.ready", {31'd0, sif.ready}, 32'd1);
        chk("midrst.busy",  {31'd0, sif.busy},  32'd0);
        chk("midrst.out",   sif.out, 32'd0);
        chk("midrst.zero",  {31'd0, sif.zero},  32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst.no_done", {31'd0, sif.done}, 32'd0);
            @(posedge clk);
            #1;
        end
        run_txn("post_rst", 32'hABCD_0000, 5'd16, 2'b01, 2, 32'h0000_ABCD, 1'b0, 1'b0);

`ifdef SHIFT_SEQ_ROTATE_EN
        run_txn("op11",     32'h0000_0001, 5'd1,  2'b11, 1, 32'h8000_0000, 1'b0, 1'b0);
        run_txn("rot12",    32'h1234_5678, 5'd12, 2'b11, 2, 32'h6781_2345, 1'b0, 1'b0);
`else
        run_txn("op11",     32'h0000_0001, 5'd1,  2'b11, 1, 32'h0000_0000, 1'b1, 1'b0);
        run_txn("op11_12",  32'h1234_5678, 5'd12, 2'b11, 2, 32'h0001_2345, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_seq32.md
Name: shift_seq32

Overview:
- Multi-cycle 32-bit shift unit for the ALU shift path. Handles sll/srl/sra and their variable forms.
- Accepts one operand and shift amount per transaction over a start/ready handshake.
- Shifts by up to STEP bits per cycle, then presents the registered result to the ALU result mux with a one-cycle done pulse.
- Sits directly downstream of ALU control decode and upstream of the result mux. Replaces a wide single-cycle barrel for multi-cycle configurations.

Parameters:
- WIDTH, 32, operand/result width.
- SHW, 5, shift-amount width; must satisfy 2^SHW == WIDTH.
- STEP, 8, maximum bits shifted per RUN cycle; a power of two, 1..WIDTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request; sampled only while ready=1.
- a  input  WIDTH  operand.
- shamt  input  SHW  shift amount.
- op  input  2  00=sll, 01=srl, 10=sra, 11=reserved (see Optional Feature).
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result valid.
- out  output  WIDTH  registered result; held until the next done.
- zero  output  1  (out == 0); registered together with out.

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-RUN):
  - state=IDLE, ready=1, busy=0, done=0, out=0, zero=1.
  - Internal accumulator and remaining count cleared.
  - An in-flight transaction is discarded, with no done pulse.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE, start=1:
  - Capture a into acc, shamt into rem, op into opr.
  - If shamt==0, go to DONE; else go to RUN.
  - start=0: stay in IDLE.
- RUN, each cycle:
  - step = min(rem, STEP).
  - Update acc:
    - sll: acc << step, zero fill.
    - srl: acc >> step, zero fill.
    - sra: acc >> step, filled with acc[WIDTH-1].
  - rem = rem - step.
  - If the new rem==0, go to DONE.
- DONE, one cycle:
  - done=1; out and zero updated from acc on entry to DONE.
  - Go to IDLE unconditionally.
- start in RUN or DONE is ignored. No queuing; the upstream holds start until it sees ready.
- Latency, start accepted at edge T (ready=1, start=1):
  - done is high in cycle T+1+ceil(shamt/STEP).
  - shamt=0: done at T+1, out=a.
  - STEP=8, shamt=31: 4 RUN cycles, done at T+5.
- Throughput: a new start is accepted the cycle after done, when ready returns to 1.
- Arithmetic:
  - Shift is never by WIDTH or more; shamt max = WIDTH-1.
  - sra of negative operands fills ones. Example: 0x80000000 sra 31 = 0xFFFFFFFF.
- out and zero are stable between done pulses. Inputs a/shamt/op may change freely after capture.

Optional Feature:
- Macro: SHIFT_SEQ_ROTATE_EN.
- Defined: op=11 is rotate right. Each RUN step does acc = {acc[step-1:0], acc[WIDTH-1:step]}. Timing is identical to the shift ops.
- Undefined: op=11 behaves exactly as srl. No extra logic is generated.

Test Plan:
- Reset, then start with a=0x0000_00F0, shamt=4, op=sll -> done at T+2, out=0x0000_0F00, zero=0, ready back high at T+3.
- a=0x8000_0000, shamt=31, op=sra, STEP=8 -> busy for 4 cycles, done at T+5, out=0xFFFF_FFFF; repeat with op=srl -> out=0x0000_0001.
- a=0x1234_5678, shamt=0, any op -> done at T+1, out=0x1234_5678; a=0xFFFF_FFFF, shamt=31, op=sll -> out=0x8000_0000; a=1, shamt=1, op=srl -> out=0, zero=1.
- Pulse start repeatedly during RUN with different a -> ignored; result matches the first transaction; exactly one done pulse.
- Drive rst_n=0 for one edge in the 2nd RUN cycle of a shamt=20 transaction -> next cycle ready=1, out=0, zero=1, done never asserts; a following transaction completes correctly.
- With SHIFT_SEQ_ROTATE_EN: a=0x0000_0001, shamt=1, op=11 -> out=0x8000_0000. Without it: same stimulus -> out=0x0000_0000, zero=1.
